match_lock_monitor: RTL and testbench
=====================================

MATCH_LOCK_MONITOR -- requirements
Module: match_lock_monitor

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
- REQ-002: Parameters SHALL be, one per line:
  - LOCK_LEN, default 8: consecutive matches needed to declare lock (range 1..2**CNT_W-1).
  - UNLOCK_LEN, default 2: consecutive mismatches needed to drop lock (range 1..15).
  - CNT_W, default 8: width of the run and error counters.
- REQ-003: Ports SHALL be, one per line:
  - clk, input, 1: clock, rising edge.
  - rst, input, 1: synchronous active-high reset.
  - z_valid, input, 1: z is sampled this cycle.
  - z, input, 1: comparator equality result (1 = x equals y).
  - clear, input, 1: synchronous soft clear.
  - locked, output, 1: state is LOCKED or HOLD.
  - state, output, 2: FSM state encoding.
  - run_len, output, CNT_W: current consecutive-match count, saturating.
  - err_cnt, output, CNT_W: total mismatch count, saturating.
  - lock_pulse, output, 1: one-cycle pulse on entry to LOCKED from SEARCH.
  - lost_pulse, output, 1: one-cycle pulse on return to SEARCH from LOCKED or HOLD.

Function
- REQ-004: All outputs SHALL be registered and SHALL reflect a sample exactly 1 cycle after the clk edge at which z_valid=1.
- REQ-005: Cycles with z_valid=0 SHALL leave state, run_len, err_cnt and the miss count unchanged, and SHALL drive lock_pulse and lost_pulse to 0.
- REQ-006: FSM states SHALL be SEARCH=0, LOCKED=1 and HOLD=2; encoding 3 is illegal and SHALL recover to SEARCH on the next edge.
- REQ-007: In SEARCH, a match SHALL increment run_len; when the incremented value equals LOCK_LEN, the FSM SHALL enter LOCKED and assert lock_pulse.
- REQ-008: In SEARCH, a mismatch SHALL set run_len to 0.
- REQ-009: In LOCKED, a match SHALL increment run_len, saturating at 2**CNT_W-1.
- REQ-010: In LOCKED, a mismatch SHALL set the miss count to 1 and enter HOLD; if UNLOCK_LEN=1 it SHALL instead enter SEARCH, set run_len to 0 and assert lost_pulse.
- REQ-011: In HOLD, a match SHALL enter LOCKED, set the miss count to 0 and set run_len to 1; lock_pulse SHALL NOT assert.
- REQ-012: In HOLD, a mismatch SHALL increment the miss count; when the count reaches UNLOCK_LEN, the FSM SHALL enter SEARCH, set run_len to 0 and assert lost_pulse.
- REQ-013: err_cnt SHALL increment on every sampled mismatch in any state and SHALL saturate at 2**CNT_W-1 (no wrap).
- REQ-014: clear=1 SHALL have the same effect as rst; when clear and z_valid are both 1, clear wins and the sample is discarded.
- REQ-015: LOCK_LEN=1 SHALL lock on the first sampled match.

Reset
- REQ-016: On rst=1 at a clk edge, the block SHALL set state=SEARCH, locked=0, run_len=0, err_cnt=0, miss count=0, lock_pulse=0 and lost_pulse=0.
- REQ-017: rst SHALL override clear and z_valid; a reset asserted during HOLD or LOCKED SHALL NOT produce lost_pulse.

Configuration
- REQ-018: With macro MATCH_MON_ERRCNT_EN defined, err_cnt SHALL be implemented per REQ-013.
- REQ-019: Without MATCH_MON_ERRCNT_EN, err_cnt SHALL be a constant 0, no error-counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
- REQ-020: Package match_mon_pkg SHALL hold the state encoding constants (SEARCH, LOCKED, HOLD) and the default values of LOCK_LEN, UNLOCK_LEN and CNT_W.
- REQ-021: A sub-module sat_counter (parameter W; inputs clr, inc; output q saturating at all-ones) SHALL be used for both run_len and err_cnt.

Verification
- REQ-022: The bench SHALL cover the following directed scenarios:
  - Reset, then 8 valid matches (LOCK_LEN=8) -> lock_pulse exactly 1 cycle after the 8th sample; locked=1; run_len=8.
  - 7 matches, 1 mismatch, 8 matches -> no lock until the final 8th match; run_len=0 after the mismatch; err_cnt=1.
  - Locked, 1 mismatch, 1 match -> HOLD then LOCKED; locked stays 1; run_len=1; lost_pulse never asserts.
  - Locked, 2 mismatches (UNLOCK_LEN=2) -> lost_pulse 1 cycle after the 2nd mismatch; state=SEARCH; run_len=0.
  - CNT_W=4, 20 mismatches -> err_cnt stops at 15; rebuild without the macro -> err_cnt=0 throughout.
  - clear and z_valid=1 asserted together mid-HOLD -> next cycle all outputs at reset values; no lost_pulse; gaps with z_valid=0 leave every output unchanged.

Source files
------------

// File: rtl/match_mon_pkg.sv
// Shared constants for the match/lock monitor: FSM state encoding and
// default parameter values.
package match_mon_pkg;

    localparam int unsigned LOCK_LEN_DEF   = 8;
    localparam int unsigned UNLOCK_LEN_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 8;

    // Width of the miss counter (UNLOCK_LEN is at most 15).
    localparam int unsigned MISS_W = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk - clock, rising edge
//   clr - synchronous clear; when inc is also high the counter loads 1
//   inc - increment request; holds at all-ones
//   q   - counter value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // clr+inc means "restart a run with this sample already counted".
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/match_lock_monitor.sv
// Match/lock monitor: tracks a stream of comparator results and declares
// lock after LOCK_LEN consecutive matches, drops it after UNLOCK_LEN
// consecutive mismatches.
// Optional feature: define MATCH_MON_ERRCNT_EN to build the saturating
// mismatch counter on err_cnt; otherwise err_cnt is tied to 0.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   z_valid, z  - sample strobe and comparator equality result
//   clear       - synchronous soft clear (same effect as rst)
//   locked      - state is LOCKED or HOLD
//   state       - FSM state encoding
//   run_len     - consecutive-match count (saturating)
//   err_cnt     - total mismatch count (saturating)
//   lock_pulse  - SEARCH -> LOCKED entry
//   lost_pulse  - LOCKED/HOLD -> SEARCH return
module match_lock_monitor
    import match_mon_pkg::*;
#(
    parameter int unsigned LOCK_LEN   = LOCK_LEN_DEF,
    parameter int unsigned UNLOCK_LEN = UNLOCK_LEN_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_valid,
    input  logic             z,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lock_pulse,
    output logic             lost_pulse
);

    localparam int unsigned CW1 = CNT_W + 1;
    localparam int unsigned MW1 = MISS_W + 1;

    state_t              state_q;
    state_t              state_n;
    logic [MISS_W-1:0]   miss_q;
    logic [MISS_W-1:0]   miss_n;
    logic                flush;
    logic                run_clr;
    logic                run_inc;
    logic                locked_n;
    logic                lock_pulse_n;
    logic                lost_pulse_n;
    logic [CNT_W:0]      run_plus;
    logic [MISS_W:0]     miss_plus;

    assign flush     = rst | clear;
    assign run_plus  = {1'b0, run_len} + CW1'(1);
    assign miss_plus = {1'b0, miss_q} + MW1'(1);

    // State register (also holds the registered outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            miss_q     <= '0;
            locked     <= 1'b0;
            lock_pulse <= 1'b0;
            lost_pulse <= 1'b0;
        end else begin
            state_q    <= state_n;
            miss_q     <= miss_n;
            locked     <= locked_n;
            lock_pulse <= lock_pulse_n;
            lost_pulse <= lost_pulse_n;
        end
    end

    // Next-state, miss count and run counter control.
    always_comb begin
        state_n = state_q;
        miss_n  = miss_q;
        run_clr = 1'b0;
        run_inc = 1'b0;
        if (flush) begin
            state_n = SEARCH;
            miss_n  = '0;
            run_clr = 1'b1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (z_valid) begin
                        if (z) begin
                            run_inc = 1'b1;
                            if (run_plus == CW1'(LOCK_LEN)) begin
                                state_n = LOCKED;
                            end
                        end else begin
                            run_clr = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (z_valid) begin
                        if (z) begin
                            run_inc = 1'b1;
                        end else if (UNLOCK_LEN == 1) begin
                            state_n = SEARCH;
                            miss_n  = '0;
                            run_clr = 1'b1;
                        end else begin
                            state_n = HOLD;
                            miss_n  = MISS_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (z_valid) begin
                        if (z) begin
                            // Recovered: restart the run counting this match.
                            state_n = LOCKED;
                            miss_n  = '0;
                            run_clr = 1'b1;
                            run_inc = 1'b1;
                        end else if (miss_plus == MW1'(UNLOCK_LEN)) begin
                            state_n = SEARCH;
                            miss_n  = '0;
                            run_clr = 1'b1;
                        end else begin
                            miss_n = miss_plus[MISS_W-1:0];
                        end
                    end
                end
                default: begin
                    state_n = SEARCH;
                    miss_n  = '0;
                end
            endcase
        end
    end

    // Output decode from the transition being taken.
    always_comb begin
        locked_n     = (state_n == LOCKED) || (state_n == HOLD);
        lock_pulse_n = !flush && z_valid && (state_q == SEARCH) && (state_n == LOCKED);
        lost_pulse_n = !flush && ((state_q == LOCKED) || (state_q == HOLD)) &&
                       (state_n == SEARCH);
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_run (
        .clk (clk),
        .clr (run_clr),
        .inc (run_inc),
        .q   (run_len)
    );

`ifdef MATCH_MON_ERRCNT_EN
    logic err_inc;

    // A discarded sample (clear/rst) never counts as an error.
    assign err_inc = !flush && z_valid && !z;

    sat_counter #(.W(CNT_W)) u_err (
        .clk (clk),
        .clr (flush),
        .inc (err_inc),
        .q   (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_match_lock_monitor.sv
// Directed bench for match_lock_monitor: a default-parameter instance driven
// from a vector table, and a CNT_W=4 / LOCK_LEN=1 / UNLOCK_LEN=1 instance
// driven by hand-written sequences.
module tb_match_lock_monitor;
    import match_mon_pkg::*;

`ifdef MATCH_MON_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef struct {
        logic   rst;
        logic   clear;
        logic   zv;
        logic   z;
        state_t st;
        int     run;
        int     err;
        logic   lp;
        logic   lsp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, clear = 1'b0, z_valid = 1'b0, z = 1'b0;
    logic       locked, lock_pulse, lost_pulse;
    logic [1:0] state;
    logic [7:0] run_len, err_cnt;

    logic       rst4 = 1'b1, clear4 = 1'b0, zv4 = 1'b0, z4 = 1'b0;
    logic       locked4, lock_pulse4, lost_pulse4;
    logic [1:0] state4;
    logic [3:0] run_len4, err_cnt4;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    match_lock_monitor dut (
        .clk(clk), .rst(rst), .z_valid(z_valid), .z(z), .clear(clear),
        .locked(locked), .state(state), .run_len(run_len), .err_cnt(err_cnt),
        .lock_pulse(lock_pulse), .lost_pulse(lost_pulse)
    );

    match_lock_monitor #(.LOCK_LEN(1), .UNLOCK_LEN(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .z_valid(zv4), .z(z4), .clear(clear4),
        .locked(locked4), .state(state4), .run_len(run_len4), .err_cnt(err_cnt4),
        .lock_pulse(lock_pulse4), .lost_pulse(lost_pulse4)
    );

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d exp=%0d", nm, idx, act, exp);
        end
    endtask

    function automatic void push(input logic r, input logic c, input logic v, input logic zz,
                                 input state_t s, input int run, input int err,
                                 input logic lp, input logic lsp);
        vec_t t;
        t.rst = r; t.clear = c; t.zv = v; t.z = zz; t.st = s;
        t.run = run; t.err = err * ERR_EN; t.lp = lp; t.lsp = lsp;
        vecs.push_back(t);
    endfunction

    // Seven matches from a cleared SEARCH state.
    function automatic void push_seven(input int err);
        for (int k = 1; k <= 7; k++) push(0, 0, 1, 1, SEARCH, k, err, 0, 0);
    endfunction

    task automatic step4(input logic v, input logic zz);
        zv4 = v; z4 = zz;
        @(posedge clk); #1;
    endtask

    initial begin
        int lp_count;

        // Reset, then lock with 8 matches.
        push(1, 0, 0, 0, SEARCH, 0, 0, 0, 0);
        push_seven(0);
        push(0, 0, 1, 1, LOCKED, 8, 0, 1, 0);
        push(0, 0, 0, 1, LOCKED, 8, 0, 0, 0);
        push(0, 0, 1, 1, LOCKED, 9, 0, 0, 0);
        // Single miss then recovery: HOLD then LOCKED with run restarted at 1.
        push(0, 0, 1, 0, HOLD,   9, 1, 0, 0);
        push(0, 0, 1, 1, LOCKED, 1, 1, 0, 0);
        // Two misses with a gap between them: lock lost on the second.
        push(0, 0, 1, 0, HOLD,   1, 2, 0, 0);
        push(0, 0, 0, 0, HOLD,   1, 2, 0, 0);
        push(0, 0, 1, 0, SEARCH, 0, 3, 0, 1);
        push(0, 0, 0, 0, SEARCH, 0, 3, 0, 0);
        // 7 matches, mismatch, then 8 matches.
        push_seven(3);
        push(0, 0, 1, 0, SEARCH, 0, 4, 0, 0);
        push_seven(4);
        push(0, 0, 0, 1, SEARCH, 7, 4, 0, 0);
        push(0, 0, 1, 1, LOCKED, 8, 4, 1, 0);
        // Clear together with a sample while in HOLD.
        push(0, 0, 1, 0, HOLD,   8, 5, 0, 0);
        push(0, 1, 1, 0, SEARCH, 0, 0, 0, 0);
        push(0, 0, 0, 1, SEARCH, 0, 0, 0, 0);
        // Relock, enter HOLD, then reset with a sample present.
        push_seven(0);
        push(0, 0, 1, 1, LOCKED, 8, 0, 1, 0);
        push(0, 0, 1, 0, HOLD,   8, 1, 0, 0);
        push(1, 0, 1, 0, SEARCH, 0, 0, 0, 0);
        push(0, 0, 0, 0, SEARCH, 0, 0, 0, 0);
        push(0, 0, 1, 1, SEARCH, 1, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; clear = vecs[i].clear;
            z_valid = vecs[i].zv; z = vecs[i].z;
            @(posedge clk); #1;
            chk("state",      i, int'(state),      int'(vecs[i].st));
            chk("locked",     i, int'(locked),
                int'((vecs[i].st == LOCKED) || (vecs[i].st == HOLD)));
            chk("run_len",    i, int'(run_len),    vecs[i].run);
            chk("err_cnt",    i, int'(err_cnt),    vecs[i].err);
            chk("lock_pulse", i, int'(lock_pulse), int'(vecs[i].lp));
            chk("lost_pulse", i, int'(lost_pulse), int'(vecs[i].lsp));
        end
        rst = 1'b0; z_valid = 1'b0;

        // Narrow instance: LOCK_LEN=1, UNLOCK_LEN=1, CNT_W=4.
        rst4 = 1'b1;
        step4(0, 0);
        rst4 = 1'b0;
        chk("w4_reset_state", 0, int'(state4),   int'(SEARCH));
        chk("w4_reset_err",   0, int'(err_cnt4), 0);
        step4(1, 1);
        chk("w4_lock1_state", 1, int'(state4),      int'(LOCKED));
        chk("w4_lock1_pulse", 1, int'(lock_pulse4), 1);
        chk("w4_lock1_run",   1, int'(run_len4),    1);
        step4(1, 0);
        chk("w4_unlock1_state", 2, int'(state4),       int'(SEARCH));
        chk("w4_unlock1_pulse", 2, int'(lost_pulse4),  1);
        chk("w4_unlock1_run",   2, int'(run_len4),     0);
        chk("w4_unlock1_err",   2, int'(err_cnt4),     ERR_EN);
        for (int k = 2; k <= 20; k++) begin
            step4(1, 0);
            chk("w4_err_sat", k + 1, int'(err_cnt4), ERR_EN * ((k < 15) ? k : 15));
            chk("w4_no_lost", k + 1, int'(lost_pulse4), 0);
        end
        lp_count = 0;
        for (int k = 1; k <= 16; k++) begin
            step4(1, 1);
            if (lock_pulse4) lp_count++;
            chk("w4_run_sat", k + 21, int'(run_len4), (k < 15) ? k : 15);
        end
        chk("w4_lock_pulse_count", 37, lp_count, 1);
        chk("w4_locked_end",       37, int'(locked4), 1);
        chk("w4_err_hold",         37, int'(err_cnt4), ERR_EN * 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
